// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises a latched pattern MSB-first as a train of
// (rep+1) frames of len bits, separated by gap idle cycles, then pulses done.
module seq_pattern_tx #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [3:0]    len,
    input  logic [3:0]    rep,
    input  logic [3:0]    gap,
    output logic          data,
    output logic          valid,
    output logic          busy,
    output logic          frame_start,
    output logic          done,
    output logic          err
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Transfer configuration captured on the accepting edge
    logic [PW-1:0] pat_q, pat_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] rep_q, rep_d;
    logic [CW-1:0] gap_q, gap_d;

    // Bit index shown on data, frames already finished, gap cycles remaining
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] frm_q, frm_d;
    logic [CW-1:0] gcnt_q, gcnt_d;

    // Registered output stage
    logic data_q, data_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic fs_q, fs_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic          len_ok_c;
    logic [PW-1:0] src_c;
    logic [PW-1:0] sh_c;

    assign len_ok_c = (len != 4'd0) && (32'(len) <= PW);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && len_ok_c) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == 4'd0) begin
                    if (frm_q == rep_q) begin
                        state_d = DONE;
                    end else if (gap_q != 4'd0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == 4'd1) begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output next values, aligned with the next state
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        frm_d   = frm_q;
        gcnt_d  = gcnt_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok_c) begin
                        pat_d   = pattern;
                        len_d   = len;
                        rep_d   = rep;
                        gap_d   = gap;
                        idx_d   = len - 4'd1;
                        frm_d   = 4'd0;
                        gcnt_d  = 4'd0;
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (idx_q != 4'd0) begin
                    idx_d   = idx_q - 4'd1;
                    valid_d = 1'b1;
                end else if (frm_q != rep_q) begin
                    if (gap_q == 4'd0) begin
                        idx_d   = len_q - 4'd1;
                        frm_d   = frm_q + 4'd1;
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                    end else begin
                        gcnt_d = gap_q;
                    end
                end else begin
                    done_d = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == 4'd1) begin
                    gcnt_d  = 4'd0;
                    idx_d   = len_q - 4'd1;
                    frm_d   = frm_q + 4'd1;
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: begin
            end
        endcase
        // The first bit comes straight from the input port; later bits from the latch
        src_c  = (state_q == IDLE) ? pattern : pat_q;
        sh_c   = src_c >> idx_d;
        data_d = valid_d & sh_c[0];
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            gcnt_q  <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle output stream compared against a
// frame/gap list model built from the configuration.
module tb_seq_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic [3:0] gap;
    logic       data;
    logic       valid;
    logic       busy;
    logic       frame_start;
    logic       done;
    logic       err;

    int tests;
    int fails;

    // Expected per-cycle tuples {busy, valid, data, frame_start, done, err}
    logic [5:0] exp_q[$];
    int          busy_cnt;
    int          det_cnt;
    int          nbits;
    logic [31:0] got_bits;

    seq_pattern_tx #(.PW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern     (pattern),
        .len         (len),
        .rep         (rep),
        .gap         (gap),
        .data        (data),
        .valid       (valid),
        .busy        (busy),
        .frame_start (frame_start),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: frames of bits MSB-first, gaps between frames, one done cycle, then idle
    task automatic build(input logic [7:0] p, input int l, input int r, input int g);
        exp_q.delete();
        for (int f = 0; f <= r; f++) begin
            for (int b = l - 1; b >= 0; b--) begin
                exp_q.push_back({1'b1, 1'b1, p[3'(b)], 1'(b == l - 1), 1'b0, 1'b0});
            end
            if (f < r) begin
                for (int k = 0; k < g; k++) exp_q.push_back(6'b100000);
            end
        end
        exp_q.push_back(6'b100010);
        exp_q.push_back(6'b000000);
    endtask

    task automatic drive(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] g, input logic s);
        pattern = p;
        len     = l;
        rep     = r;
        gap     = g;
        start   = s;
    endtask

    // Compares the DUT stream to exp_q; mode 1 scrambles pattern, mode 2 scrambles all inputs
    task automatic run_stream(input logic hold, input int mode, input string name);
        logic [5:0] obs;
        logic [3:0] win;
        int         nv;
        busy_cnt = 0;
        det_cnt  = 0;
        nbits    = 0;
        got_bits = '0;
        win      = '0;
        nv       = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs = {busy, valid, data, frame_start, done, err};
            tests++;
            if (obs !== exp_q[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: got {busy,valid,data,fs,done,err}=%b required %b",
                         name, i, obs, exp_q[i]);
            end
            if (busy) busy_cnt++;
            if (valid) begin
                got_bits = {got_bits[30:0], data};
                nbits++;
                win = {win[2:0], data};
                nv++;
                if (nv >= 4 && win == 4'b1010) det_cnt++;
            end
            if (mode >= 1) pattern = 8'($urandom);
            if (mode == 2) begin
                len   = 4'($urandom);
                rep   = 4'($urandom);
                gap   = 4'($urandom);
                start = 1'($urandom);
            end else begin
                start = hold;
            end
            if (i == exp_q.size() - 1) start = hold;
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b0;
        drive(8'hFF, 4'd4, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {busy, valid, data, frame_start, done, err};
            tests++;
            if (obs !== 6'b000000) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got %b required 000000", i, obs);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        obs = {busy, valid, data, frame_start, done, err};
        tests++;
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL reset_release: got %b required 000000", obs);
        end
    endtask

    task automatic test_basic();
        build(8'h0A, 4, 0, 0);
        drive(8'h0A, 4'd4, 4'd0, 4'd0, 1'b1);
        run_stream(1'b0, 0, "basic");
        tests++;
        if (got_bits !== 32'h0000000A || nbits != 4) begin
            fails++;
            $display("FAIL basic_bits: got %h/%0d required 0000000a/4", got_bits, nbits);
        end
        tests++;
        if (busy_cnt != 5) begin
            fails++;
            $display("FAIL basic_busy: got %0d required 5", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        build(8'h0A, 4, 2, 0);
        drive(8'h0A, 4'd4, 4'd2, 4'd0, 1'b1);
        run_stream(1'b0, 0, "b2b");
        tests++;
        if (got_bits !== 32'h00000AAA || nbits != 12) begin
            fails++;
            $display("FAIL b2b_bits: got %h/%0d required 00000aaa/12", got_bits, nbits);
        end
        tests++;
        if (det_cnt != 5) begin
            fails++;
            $display("FAIL b2b_detector: got %0d required 5", det_cnt);
        end
    endtask

    task automatic test_gap();
        build(8'hA5, 8, 1, 3);
        drive(8'hA5, 4'd8, 4'd1, 4'd3, 1'b1);
        run_stream(1'b0, 0, "gap");
        tests++;
        if (got_bits !== 32'h0000A5A5 || nbits != 16) begin
            fails++;
            $display("FAIL gap_bits: got %h/%0d required 0000a5a5/16", got_bits, nbits);
        end
        tests++;
        if (busy_cnt != 20) begin
            fails++;
            $display("FAIL gap_busy: got %0d required 20", busy_cnt);
        end
    endtask

    task automatic test_max_rep();
        build(8'h02, 2, 15, 0);
        drive(8'h02, 4'd2, 4'd15, 4'd0, 1'b1);
        run_stream(1'b0, 0, "max_rep");
        tests++;
        if (nbits != 32 || busy_cnt != 33) begin
            fails++;
            $display("FAIL max_rep_counts: got bits=%0d busy=%0d required 32/33", nbits, busy_cnt);
        end
    endtask

    task automatic test_err();
        logic [5:0] obs;
        logic [3:0] bad[3];
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        bad[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, bad[i], 4'd0, 4'd0, 1'b1);
            @(negedge clk);
            obs = {busy, valid, data, frame_start, done, err};
            tests++;
            if (obs !== 6'b000001) begin
                fails++;
                $display("FAIL err_len%0d: got %b required 000001", bad[i], obs);
            end
        end
        start = 1'b0;
        @(negedge clk);
        obs = {busy, valid, data, frame_start, done, err};
        tests++;
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL err_clear: got %b required 000000", obs);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        logic [7:0] p;
        p = 8'($urandom);
        build(p, 8, 3, 1);
        drive(p, 4'd8, 4'd3, 4'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {busy, valid, data, frame_start, done, err};
            tests++;
            if (obs !== exp_q[i]) begin
                fails++;
                $display("FAIL rst_mid_pre cycle %0d: got %b required %b", i, obs, exp_q[i]);
            end
            start = 1'b0;
        end
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {busy, valid, data, frame_start, done, err};
            tests++;
            if (obs !== 6'b000000) begin
                fails++;
                $display("FAIL rst_mid_abort cycle %0d: got %b required 000000", i, obs);
            end
        end
        reset = 1'b1;
        p = 8'($urandom);
        build(p, 3, 0, 0);
        drive(p, 4'd3, 4'd0, 4'd0, 1'b1);
        run_stream(1'b0, 0, "rst_mid_restart");
    endtask

    task automatic test_start_held();
        logic [7:0] p;
        p = 8'($urandom);
        build(p, 5, 1, 2);
        drive(p, 4'd5, 4'd1, 4'd2, 1'b1);
        run_stream(1'b1, 1, "held_first");
        build(pattern, 5, 1, 2);
        run_stream(1'b0, 0, "held_second");
    endtask

    task automatic test_random();
        logic [7:0] p;
        int l, r, g;
        for (int n = 0; n < 25; n++) begin
            p = 8'($urandom);
            l = int'($urandom_range(8, 1));
            r = int'($urandom_range(15, 0));
            g = int'($urandom_range(15, 0));
            build(p, l, r, g);
            drive(p, 4'(l), 4'(r), 4'(g), 1'b1);
            run_stream(1'b0, 2, "random");
            tests++;
            if (busy_cnt != (r + 1) * l + r * g + 1) begin
                fails++;
                $display("FAIL random_busy len=%0d rep=%0d gap=%0d: got %0d required %0d",
                         l, r, g, busy_cnt, (r + 1) * l + r * g + 1);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        drive(8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_max_rep();
        test_err();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PW, default 8, the maximum pattern width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset), sampled on rising clk.
REQ-004 SHALL have port start, input, 1, request to transmit; sampled only in IDLE.
REQ-005 SHALL have port pattern, input, PW, the bits to send, MSB-first from bit len-1 down to bit 0.
REQ-006 SHALL have port len, input, 4, the number of pattern bits per frame; legal range 1..PW.
REQ-007 SHALL have port rep, input, 4, the frame count minus one (0 -> 1 frame, 15 -> 16 frames).
REQ-008 SHALL have port gap, input, 4, the idle cycles inserted between frames (0..15).
REQ-009 SHALL have port data, output, 1, the serial bit stream, registered.
REQ-010 SHALL have port valid, output, 1, high while data carries a pattern bit.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse coincident with the first bit of each frame.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last bit of the last frame.
REQ-014 SHALL have port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-015 SHALL implement four states: IDLE, SHIFT, GAP and DONE.
REQ-016 IDLE: on start=1 with 1<=len<=PW, SHALL latch pattern, len, rep and gap into internal registers and enter SHIFT on the same edge.
REQ-017 IDLE: on start=1 with len=0 or len>PW, SHALL stay in IDLE, pulse err for one cycle and latch nothing.
REQ-018 The first bit (pattern[len-1]) SHALL appear on data with valid=1 and frame_start=1 in the cycle after the accepting edge; start-to-first-bit latency is 1 cycle.
REQ-019 SHIFT: each bit SHALL be held for exactly one cycle; the bit index decrements each cycle.
REQ-020 SHIFT after bit 0 with frames remaining and gap>0: SHALL enter GAP, with data=0 and valid=0 for exactly gap cycles.
REQ-021 SHIFT after bit 0 with frames remaining and gap=0: frames SHALL run back-to-back; the next frame's MSB follows bit 0 in the next cycle, and frame_start pulses again.
REQ-022 GAP expiry: SHALL re-enter SHIFT at index len-1 and pulse frame_start with the first bit.
REQ-023 SHIFT after bit 0 of the last frame: SHALL enter DONE for one cycle with done=1, data=0 and valid=0, then return to IDLE.
REQ-024 Total busy cycles SHALL equal (rep+1)*len + rep*gap + 1.
REQ-025 start SHALL be ignored while busy=1; changes on pattern, len, rep or gap during a transfer SHALL NOT affect the transfer in progress.
REQ-026 start=1 during the DONE cycle SHALL be ignored; a new transfer can be accepted in the first IDLE cycle at the earliest.
REQ-027 When valid=0, data SHALL be 0.
REQ-028 The frame counter and bit counter SHALL NOT wrap; rep=15 yields exactly 16 frames.

Reset
REQ-029 While reset=0 at a rising edge, the block SHALL enter IDLE and clear all internal registers.
REQ-030 Reset values SHALL be: data=0, valid=0, busy=0, frame_start=0, done=0, err=0.
REQ-031 Reset asserted mid-transfer (SHIFT or GAP) SHALL abort the transfer with no done pulse; outputs SHALL take their reset values on the following cycle.
REQ-032 reset SHALL take priority over start in the same cycle.

Verification
REQ-033 pattern=8'h0A, len=4, rep=0, gap=0, one-cycle start -> data=1,0,1,0 on 4 consecutive valid cycles; frame_start on the first; done one cycle later; busy for 5 cycles.
REQ-034 pattern=8'h0A, len=4, rep=2, gap=0 -> 12 contiguous valid bits 101010101010; frame_start at bits 1, 5 and 9; a downstream 1010 overlapping detector ticks 5 times.
REQ-035 pattern=8'hA5, len=8, rep=1, gap=3 -> 10100101, then 3 cycles of valid=0 and data=0, then 10100101, then done; busy for 20 cycles.
REQ-036 start with len=0, then with len=9 -> err pulses each time; busy stays 0; data stays 0.
REQ-037 reset=0 asserted on the 3rd bit of a len=8, rep=3 transfer -> all outputs 0 the next cycle, no done pulse; a fresh start is accepted immediately after reset releases.
REQ-038 start held high continuously with pattern changing mid-frame -> the in-flight frame is unchanged; a new transfer begins one cycle after the DONE cycle.
